// File: rtl/video_pkg.sv
// Shared types and constants for the 5x5 median-filter window datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VBLANK  = 2'd1,
    LINE    = 2'd2,
    HBLANK  = 2'd3
  } vwc_state_t;

  localparam int KERNEL_SIZE = 5;
  localparam int LB_COUNT    = 4;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that keeps sync/qualifier bits aligned with a datapath.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; free-running every clock.
module sync_delay #(
  parameter int DEPTH = 5,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  // Shift one stage per clock; reset flushes the whole pipe so no stale sync leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/video_window_ctrl.sv
// Raster tracker and line-buffer sequencer for the 5x5 window; optional status via VWC_STATUS_EN.
// Latency: addressing/valid outputs 1 cycle after rx_dv; tx_* delayed PIPE_DLY+1 cycles.
// Backpressure: none; follows the incoming video timing, overflow is flagged not stalled.
module video_window_ctrl
  import video_pkg::*;
#(
  parameter  int MAX_W    = 2048,
  parameter  int MAX_H    = 2048,
  parameter  int PIPE_DLY = 4,
  localparam int AW       = $clog2(MAX_W),
  localparam int RW       = $clog2(MAX_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_dv,
  input  logic          rx_hs,
  input  logic          rx_vs,
  output logic          lb_wr_en,
  output logic [AW-1:0] lb_addr,
  output logic [1:0]    lb_wr_sel,
  output logic [AW-1:0] col,
  output logic [RW-1:0] row,
  output logic          win_valid,
  output logic          ovf,
  output logic          tx_dv,
  output logic          tx_hs,
  output logic          tx_vs
`ifdef VWC_STATUS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [AW-1:0] meas_w,
  output logic [RW-1:0] meas_h
`endif
);

  // Counters carry one extra bit so "one past the last position" marks saturation.
  localparam int CW = AW + 1;
  localparam int HW = RW + 1;
  localparam logic [CW-1:0] COL_FULL = CW'(MAX_W);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [AW-1:0] COL_LAST = AW'(MAX_W - 1);
  localparam logic [AW-1:0] COL_WIN  = AW'(KERNEL_SIZE - 1);
  localparam logic [HW-1:0] ROW_FULL = HW'(MAX_H);
  localparam logic [HW-1:0] ROW_ONE  = HW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAX_H - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KERNEL_SIZE - 1);
  localparam logic [1:0]    SEL_LAST = 2'(LB_COUNT - 1);

  vwc_state_t    state, state_nxt;
  logic          vs_q;
  logic          vs_rise;
  logic [CW-1:0] col_cnt, col_cnt_nxt;
  logic [HW-1:0] row_cnt, row_cnt_nxt;
  logic          col_full, row_full;
  logic          take_pix;
  logic          wr_en_nxt, win_nxt, ovf_nxt;
  logic [AW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic [1:0]    sel_nxt;
  logic [2:0]    tx_bus;

  assign vs_rise  = rx_vs & ~vs_q;
  assign col_full = (col_cnt == COL_FULL);
  assign row_full = (row_cnt == ROW_FULL);
  // Read and write share one column address (read-before-write RAMs).
  assign lb_addr  = col;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_VS;
    else     state <= state_nxt;
  end

  // Next state plus next values of every counter and registered output; vs edge overrides all.
  always_comb begin
    state_nxt   = state;
    col_cnt_nxt = col_cnt;
    row_cnt_nxt = row_cnt;
    sel_nxt     = lb_wr_sel;
    col_nxt     = col;
    row_nxt     = row;
    wr_en_nxt   = 1'b0;
    win_nxt     = 1'b0;
    ovf_nxt     = ovf;
    take_pix    = 1'b0;

    if (vs_rise) begin
      state_nxt   = VBLANK;
      col_cnt_nxt = '0;
      row_cnt_nxt = '0;
      sel_nxt     = 2'd0;
      col_nxt     = '0;
      row_nxt     = '0;
      ovf_nxt     = 1'b0;
    end else begin
      case (state)
        WAIT_VS: ;
        VBLANK, HBLANK: begin
          if (rx_dv) begin
            state_nxt = LINE;
            take_pix  = 1'b1;
          end
        end
        LINE: begin
          if (rx_dv) begin
            take_pix = 1'b1;
          end else begin
            state_nxt   = HBLANK;
            col_cnt_nxt = '0;
            if (!row_full) row_cnt_nxt = row_cnt + ROW_ONE;
            sel_nxt = (lb_wr_sel == SEL_LAST) ? 2'd0 : lb_wr_sel + 2'd1;
          end
        end
        default: state_nxt = WAIT_VS;
      endcase
    end

    if (take_pix) begin
      col_nxt   = col_full ? COL_LAST : col_cnt[AW-1:0];
      row_nxt   = row_full ? ROW_LAST : row_cnt[RW-1:0];
      wr_en_nxt = !col_full && !row_full;
      if (!col_full)  col_cnt_nxt = col_cnt + COL_ONE;
      if (!wr_en_nxt) ovf_nxt = 1'b1;
      win_nxt   = wr_en_nxt && (row_nxt >= ROW_WIN) && (col_nxt >= COL_WIN);
    end
  end

  // Register raster counters and all addressing/valid outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      lb_wr_sel <= 2'd0;
      col       <= '0;
      row       <= '0;
      lb_wr_en  <= 1'b0;
      win_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      vs_q      <= rx_vs;
      col_cnt   <= col_cnt_nxt;
      row_cnt   <= row_cnt_nxt;
      lb_wr_sel <= sel_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      lb_wr_en  <= wr_en_nxt;
      win_valid <= win_nxt;
      ovf       <= ovf_nxt;
    end
  end

  sync_delay #(
    .DEPTH (PIPE_DLY + 1),
    .W     (3)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({rx_dv, rx_hs, rx_vs}),
    .dout (tx_bus)
  );

  assign {tx_dv, tx_hs, tx_vs} = tx_bus;

`ifdef VWC_STATUS_EN
  // Frame count and measured geometry; counts are clamped to the output width when saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      meas_w    <= '0;
      meas_h    <= '0;
    end else begin
      if (vs_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
        meas_h    <= row_full ? ROW_LAST : row_cnt[RW-1:0];
      end
      if (!vs_rise && state == LINE && !rx_dv) begin
        meas_w <= col_full ? COL_LAST : col_cnt[AW-1:0];
      end
    end
  end
`endif

endmodule
